cpu_exec_core: RTL and testbench
================================

Name: cpu_exec_core

Overview:
- Execution core of the 8-bit, 4-register teaching microprocessor.
- Contains three parts:
  - a clock divider that turns the board clock into the slow processor clock;
  - a combinational main-control decoder for the 2-bit opcode;
  - an 8-bit adder ALU used for arithmetic, address generation and branch offset.
- Register file, data memory, PC and 7-segment display live outside this block and consume its outputs.

Parameters:
- HALF_PERIOD, 25000000, number of clk_in rising edges per clk_out half-period. Legal range ≥1. clk_out period = 2*HALF_PERIOD clk_in cycles.

Ports:
- clk_in  input  1  board clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- op  input  2  opcode, instruction[7:6].
- operand1  input  8  ALU operand A (rs data).
- operand2  input  8  ALU operand B (rt data or sign-extended immediate, muxed outside).
- clk_out  output  1  divided processor clock.
- reg_dst  output  1  1 = write register is rd, 0 = rt.
- reg_write  output  1  register file write enable.
- alu_src  output  1  1 = operand2 is the immediate.
- branch  output  1  PC takes pc+1+imm.
- mem_read  output  1  data memory read enable.
- mem_write  output  1  data memory write enable.
- mem_to_reg  output  1  1 = write-back data comes from memory.
- alu_op  output  1  ALU operation select; reserved, always 0 (add).
- result  output  8  ALU result.

Behaviour:
- Clock divider:
  - Internal counter, width $clog2(HALF_PERIOD)+1.
  - On reset assertion, counter=0 and clk_out=0 immediately (asynchronous), held while reset is high.
  - On each clk_in rising edge with reset low:
    - if counter==HALF_PERIOD-1: counter<=0 and clk_out toggles;
    - otherwise counter increments.
  - First clk_out rising edge occurs HALF_PERIOD clk_in edges after reset release. With HALF_PERIOD=1, clk_out toggles every clk_in edge.
  - Reset mid-period discards partial count; clk_out returns to 0.
- Control: purely combinational from op; no latency; unaffected by reset. Outputs listed as reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg, alu_op:
  - op=00 ADD (R-type): 1,1,0,0,0,0,0,0
  - op=01 LW: 0,1,1,0,1,0,1,0
  - op=10 SW: 0,0,1,0,0,1,0,0
  - op=11 J (unconditional relative branch): 0,0,1,0... is not used; the J row is 0,0,0,1,0,0,0,0
  - Don't-care fields are driven 0, so no X ever appears on outputs.
- ALU:
  - Combinational result = (operand1 + operand2) mod 256, two's-complement wrap; no latency.
  - Carry is discarded unless the optional feature is enabled.
- No registers other than the divider counter and clk_out.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds two outputs:
  - carry (1 bit): bit 8 of the 9-bit sum operand1+operand2;
  - zero (1 bit): high when result==0.
  - Both are combinational.
- Undefined: neither port exists; result behaviour is unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11;
  - typedef word_t (logic [7:0]);
  - packed struct ctrl_t with the eight control bits in port order.
- The control decoder is a case on op inside the top module.
- The ALU is a single continuous assignment inside the top module.
- One sub-module is natural: cpu_clk_div, which owns HALF_PERIOD, the counter and clk_out, and is reusable elsewhere.

Test Plan:
- HALF_PERIOD=3:
  - Assert reset 2 cycles, then release → clk_out=0 for 3 clk_in edges, rises on the 3rd, falls on the 6th; period = 6 cycles.
  - Assert reset asynchronously mid-high-phase → clk_out=0 immediately without a clk_in edge; after release, first rise again after 3 edges.
- Sweep op 00, 01, 10, 11 → control vectors exactly 11000000, 01101010, 00100100, 00010000.
- ALU basic sums:
  - operand1=8'h05, operand2=8'h03 → result=8'h08;
  - operand1=8'h10, operand2=8'hFF (imm −1) → result=8'h0F.
- ALU wrap with ALU_FLAGS_EN defined:
  - operand1=8'hFF, operand2=8'h01 → result=8'h00, carry=1, zero=1;
  - operand1=8'h7F, operand2=8'h01 → result=8'h80, carry=0, zero=0.
- HALF_PERIOD=1 → clk_out toggles on every clk_in rising edge after reset release; first rise at edge 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit, 4-register teaching CPU execution core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode constants, word_t, ctrl_t (control bits in port order).
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  typedef logic [7:0] word_t;

  // Field order matches the control port order of cpu_exec_core.
  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_clk_div.sv
// Clock divider: o_clk toggles every HALF_PERIOD rising edges of i_clk.
// Latency: first o_clk rise HALF_PERIOD i_clk edges after reset release.
// Backpressure: none; free-running while i_rst is low.
// Ports:
//   i_clk  board clock
//   i_rst  asynchronous active-high reset (clears count, forces o_clk low)
//   o_clk  divided clock, registered
module cpu_clk_div #(
  parameter int HALF_PERIOD = 25000000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_clk
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_clk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_clk = r_clk;

endmodule

// File: rtl/cpu_exec_core.sv
// Execution core: clock divider, 2-bit opcode control decoder, 8-bit adder ALU.
// Latency: decoder and ALU combinational; clk_out registered in cpu_clk_div.
// Backpressure: none.
// Ports:
//   clk_in, reset           board clock, async active-high reset (divider only)
//   op                      opcode, instruction[7:6]
//   operand1, operand2      ALU operands
//   clk_out                 divided processor clock
//   reg_dst..alu_op         main control signals
//   result                  (operand1 + operand2) mod 256
//   carry, zero             only when ALU_FLAGS_EN is defined
module cpu_exec_core
  import cpu_pkg::*;
#(
  parameter int HALF_PERIOD = 25000000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] op,
  input  word_t      operand1,
  input  word_t      operand2,
  output logic       clk_out,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_op,
  output word_t      result
`ifdef ALU_FLAGS_EN
  ,
  output logic       carry,
  output logic       zero
`endif
);

  ctrl_t w_ctrl;

  cpu_clk_div #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_div (
    .i_clk(clk_in),
    .i_rst(reset),
    .o_clk(clk_out)
  );

  // Unused fields stay 0 so downstream logic never sees X.
  always_comb begin
    w_ctrl = '0;
    case (op)
      OP_ADD: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_J: begin
        w_ctrl.branch = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign reg_dst    = w_ctrl.reg_dst;
  assign reg_write  = w_ctrl.reg_write;
  assign alu_src    = w_ctrl.alu_src;
  assign branch     = w_ctrl.branch;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign alu_op     = w_ctrl.alu_op;

`ifdef ALU_FLAGS_EN
  assign {carry, result} = {1'b0, operand1} + {1'b0, operand2};
  assign zero = (result == 8'h00);
`else
  // Carry out of bit 7 is intentionally dropped.
  assign result = operand1 + operand2;
`endif

endmodule

// File: tb/tb_cpu_exec_core.sv
module tb_cpu_exec_core;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] op = 2'b00;
  logic [7:0] operand1 = 8'h00;
  logic [7:0] operand2 = 8'h00;

  logic       clk_out3, clk_out1;
  logic [7:0] ctl3, ctl1;
  logic [7:0] result3, result1;
`ifdef ALU_FLAGS_EN
  logic       carry3, zero3, carry1, zero1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  cpu_exec_core #(.HALF_PERIOD(3)) u_dut3 (
    .clk_in(clk_in), .reset(reset), .op(op),
    .operand1(operand1), .operand2(operand2),
    .clk_out(clk_out3),
    .reg_dst(ctl3[7]), .reg_write(ctl3[6]), .alu_src(ctl3[5]), .branch(ctl3[4]),
    .mem_read(ctl3[3]), .mem_write(ctl3[2]), .mem_to_reg(ctl3[1]), .alu_op(ctl3[0]),
    .result(result3)
`ifdef ALU_FLAGS_EN
    , .carry(carry3), .zero(zero3)
`endif
  );

  cpu_exec_core #(.HALF_PERIOD(1)) u_dut1 (
    .clk_in(clk_in), .reset(reset), .op(op),
    .operand1(operand1), .operand2(operand2),
    .clk_out(clk_out1),
    .reg_dst(ctl1[7]), .reg_write(ctl1[6]), .alu_src(ctl1[5]), .branch(ctl1[4]),
    .mem_read(ctl1[3]), .mem_write(ctl1[2]), .mem_to_reg(ctl1[1]), .alu_op(ctl1[0]),
    .result(result1)
`ifdef ALU_FLAGS_EN
    , .carry(carry1), .zero(zero1)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: control vectors straight from the opcode table.
  function automatic logic [7:0] ref_ctrl(input logic [1:0] o);
    logic [7:0] tbl [4];
    tbl[0] = 8'b1100_0000;  // ADD
    tbl[1] = 8'b0110_1010;  // LW
    tbl[2] = 8'b0010_0100;  // SW
    tbl[3] = 8'b0001_0000;  // J
    return tbl[o];
  endfunction

  // Reference: clk_out level after n clk_in edges since reset release.
  function automatic int ref_clk(input int n, input int hp);
    return (n / hp) % 2;
  endfunction

  task automatic check_div(input int n);
    check($sformatf("clk_out hp3 edge %0d", n), int'(clk_out3), ref_clk(n, 3));
    check($sformatf("clk_out hp1 edge %0d", n), int'(clk_out1), ref_clk(n, 1));
  endtask

  task automatic check_comb(input string tag, input logic [7:0] exp_res);
    int sum;
    sum = int'(operand1) + int'(operand2);
    check({tag, " ctrl"}, int'(ctl3), int'(ref_ctrl(op)));
    check({tag, " ctrl hp1"}, int'(ctl1), int'(ref_ctrl(op)));
    check({tag, " result"}, int'(result3), int'(exp_res));
    check({tag, " result hp1"}, int'(result1), int'(exp_res));
`ifdef ALU_FLAGS_EN
    check({tag, " carry"}, int'(carry3), (sum >= 256) ? 1 : 0);
    check({tag, " zero"}, int'(zero3), ((sum % 256) == 0) ? 1 : 0);
`else
    if (sum < 0) check({tag, " sum"}, sum, 0);
`endif
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_res;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   n;

    vecs[0] = '{2'b00, 8'h05, 8'h03, 8'b1100_0000, 8'h08};
    vecs[1] = '{2'b01, 8'h10, 8'hFF, 8'b0110_1010, 8'h0F};
    vecs[2] = '{2'b10, 8'hFF, 8'h01, 8'b0010_0100, 8'h00};
    vecs[3] = '{2'b11, 8'h7F, 8'h01, 8'b0001_0000, 8'h80};
    vecs[4] = '{2'b00, 8'h00, 8'h00, 8'b1100_0000, 8'h00};
    vecs[5] = '{2'b01, 8'h80, 8'h80, 8'b0110_1010, 8'h00};
    vecs[6] = '{2'b10, 8'hFF, 8'hFF, 8'b0010_0100, 8'hFE};
    vecs[7] = '{2'b11, 8'h3C, 8'hC3, 8'b0001_0000, 8'hFF};

    // Reset held for two clk_in edges: divider outputs must be low.
    repeat (2) @(posedge clk_in);
    #1;
    check("reset clk_out hp3", int'(clk_out3), 0);
    check("reset clk_out hp1", int'(clk_out1), 0);

    @(negedge clk_in);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      n++;
      check_div(n);
    end

    // n=10: hp3 divider is in its high phase; reset must clear it at once.
    #2;
    reset = 1'b1;
    #1;
    check("async reset hp3", int'(clk_out3), 0);
    check("async reset hp1", int'(clk_out1), 0);
    @(posedge clk_in);
    #1;
    check("reset held hp3", int'(clk_out3), 0);
    @(negedge clk_in);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in);
      #1;
      n++;
      check_div(n);
    end

    // Random reset pulses and run lengths.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk_in);
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk_in);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < int'($urandom_range(4, 14)); i++) begin
        @(posedge clk_in);
        #1;
        n++;
        check_div(n);
      end
    end

    // Table-driven control and ALU vectors.
    for (int i = 0; i < 8; i++) begin
      op = vecs[i].op;
      operand1 = vecs[i].a;
      operand2 = vecs[i].b;
      #1;
      check($sformatf("vec%0d ctrl", i), int'(ctl3), int'(vecs[i].exp_ctrl));
      check_comb($sformatf("vec%0d", i), vecs[i].exp_res);
    end

    // Randomized combinational stimulus against the arithmetic model.
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      operand1 = 8'($urandom_range(0, 255));
      operand2 = 8'($urandom_range(0, 255));
      #1;
      check_comb($sformatf("rand%0d", i), 8'((int'(operand1) + int'(operand2)) % 256));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
